pwm_drive_sequencer: RTL and testbench
======================================

Name: pwm_drive_sequencer

Overview:
- Supervisory controller in front of the three-phase PWM generator; owns its Duty_0..2, Enable and DeadTime_En inputs, and services its period interrupt.
- Sequences gate-drive startup: bootstrap precharge, soft ramp to commanded duties, steady-state tracking, soft ramp-down and latched fault shutdown.
- All duty changes are made only on PWM period boundaries, which are detected from the generator's Interrupt_Active output.

Parameters:
- PRECHARGE_PERIODS, 16, number of period ticks spent with all duties at 0 and low-side switching active.
- RAMP_STEP, 32'd64, maximum duty change per phase per period tick during ramp-up and ramp-down.
- WDT_CYCLES, 32'd1000000, clock cycles allowed between period ticks; used only with PWM_SEQ_WDOG_EN.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; request to run.
- Stop  in  1  level; request a soft stop, priority over Start.
- Fault  in  1  level; external fault.
- Fault_Clear  in  1  pulse; leave FAULT.
- Target_0, Target_1, Target_2  in  32 each  commanded duties.
- Pwm_Irq  in  1  the generator's Interrupt_Active.
- Duty_0, Duty_1, Duty_2  out  32 each  duties to the generator.
- Pwm_Enable  out  1  generator Enable.
- DeadTime_En  out  1  generator DeadTime_En.
- Irq_Enable  out  1  generator Interrupt_Enable.
- Irq_Clear  out  1  generator Interrupt_Clear.
- State  out  3  IDLE=0, PRECHARGE=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4, FAULT=5.
- Busy  out  1  high whenever State is not IDLE or FAULT.

Behaviour:
- Reset (asynchronous, active-low):
  - State=IDLE; Duty_0..2=0; Pwm_Enable=0; DeadTime_En=0; Irq_Clear=0; Busy=0.
  - Irq_Enable=1 in every state, including during reset.
  - Precharge counter and watchdog counter cleared.
- Tick detection:
  - Pwm_Irq is registered once into irq_q; tick = Pwm_Irq & ~irq_q.
  - Irq_Clear pulses for exactly 1 cycle, in the cycle after tick is detected.
  - All duty and state updates triggered by a tick occur in that same cycle, i.e. registered, 1 clock after the tick.
- Fault priority: Fault=1 in any state moves to FAULT on the next edge, overriding every other transition.
  - In FAULT: Pwm_Enable=0, DeadTime_En=0, Duty_0..2=0.
- IDLE:
  - Outputs as at reset.
  - Start=1 and Stop=0 -> PRECHARGE, with Pwm_Enable=1, DeadTime_En=1, Duty_0..2=0, and precharge counter cleared.
- PRECHARGE:
  - Counter increments on each tick.
  - On the tick on which the counter reaches PRECHARGE_PERIODS -> RAMP_UP.
  - Stop=1 -> IDLE immediately.
- RAMP_UP, per phase, on each tick:
  - If Duty < Target: Duty = min(Duty + RAMP_STEP, Target), using a 33-bit sum so the result never overflows.
  - If Duty > Target: Duty = max(Duty - RAMP_STEP, Target).
  - When all three duties equal their targets after an update -> RUN.
  - Stop=1 -> RAMP_DOWN.
- RUN:
  - Duty_k <= Target_k on each tick. No change between ticks, even if the targets change.
  - Stop=1 -> RAMP_DOWN.
- RAMP_DOWN:
  - On each tick, Duty = (Duty > RAMP_STEP) ? Duty - RAMP_STEP : 0.
  - When all three duties are 0 -> IDLE; Pwm_Enable and DeadTime_En drop in that same cycle.
  - Start is ignored.
- FAULT:
  - Remains in FAULT while Fault=1.
  - Fault_Clear=1 with Fault=0 -> IDLE.
  - Start is ignored until IDLE is reached, and Start must be re-asserted there.
- Simultaneous events:
  - Fault outranks Stop and tick.
  - Stop outranks Start.
  - A Stop and a tick in the same cycle in RAMP_UP or RUN: enter RAMP_DOWN and apply the first decrement in that same cycle.
- Targets are passed through without clamping; the generator clamps them to its period.
- Pwm_Irq stuck high: exactly one tick and one Irq_Clear pulse result; no further ticks until Pwm_Irq returns low.

Optional Feature:
- Macro PWM_SEQ_WDOG_EN.
- Defined:
  - A 32-bit counter runs while State is PRECHARGE, RAMP_UP, RUN or RAMP_DOWN.
  - It clears on every tick and on every state change.
  - If it reaches WDT_CYCLES -> FAULT, with the same outputs as an external fault.
  - FAULT is held until Fault_Clear.
- Not defined: no watchdog counter logic; WDT_CYCLES is unused.

Test Plan:
- Reset mid-RUN (duties 500) -> all outputs 0 and State=0 immediately, without waiting for Clk.
- PRECHARGE_PERIODS=4, Start, ticks every 100 clocks -> State=1 for exactly 4 ticks with Duty=0, Pwm_Enable=1, DeadTime_En=1; then State=2.
- RAMP_STEP=64, Targets 200/64/0 -> Duty_0 goes 64, 128, 192, 200; Duty_1=64 after the first tick; Duty_2 stays 0; State=3 after the 4th ramp tick.
- In RUN, Target_0 changes from 200 to 300 mid-period -> Duty_0 stays 200 until the next tick, then 300. Each tick gives a 1-cycle Irq_Clear.
- Stop in RUN at 200 -> Duty_0 goes 136, 72, 8, 0; then State=0 and Pwm_Enable=0.
- Fault during RAMP_UP -> next cycle State=5, Pwm_Enable=0, Duty=0. Fault_Clear while Fault=1 is ignored; Fault_Clear after Fault=0 -> State=0.
- With PWM_SEQ_WDOG_EN and WDT_CYCLES=50: no ticks in RUN -> State=5 at cycle 50.

Source files
------------

// File: rtl/pwm_drive_sequencer_if.sv
// pwm_drive_sequencer_if: link between the drive sequencer and the three-phase PWM generator
// master (sequencer): drives Duty_0..2 [31:0], Pwm_Enable, DeadTime_En, Irq_Enable, Irq_Clear; samples Pwm_Irq
// slave (generator): samples the duty/enable/interrupt controls; drives Pwm_Irq (its Interrupt_Active)
interface pwm_drive_sequencer_if;
  logic [31:0] Duty_0, Duty_1, Duty_2;
  logic Pwm_Enable, DeadTime_En, Irq_Enable, Irq_Clear, Pwm_Irq;
  modport master (output Duty_0, Duty_1, Duty_2, Pwm_Enable, DeadTime_En, Irq_Enable, Irq_Clear, input Pwm_Irq);
  modport slave (input Duty_0, Duty_1, Duty_2, Pwm_Enable, DeadTime_En, Irq_Enable, Irq_Clear, output Pwm_Irq);
endinterface

// File: rtl/pwm_drive_sequencer.sv
// pwm_drive_sequencer: gate-drive startup/shutdown sequencer in front of a three-phase PWM generator
// Ports: Clk, Reset_n (async, active-low); Start/Stop/Fault levels, Fault_Clear pulse;
//   Target_0..2 [31:0] commanded duties; pwm (master modport) to the generator;
//   State [2:0] (IDLE=0 PRECHARGE=1 RAMP_UP=2 RUN=3 RAMP_DOWN=4 FAULT=5); Busy.
// Optional: define PWM_SEQ_WDOG_EN to fault when no period tick arrives within WDT_CYCLES clocks.
module pwm_drive_sequencer #(
  parameter int unsigned PRECHARGE_PERIODS = 16,
  parameter logic [31:0] RAMP_STEP = 32'd64,
  parameter logic [31:0] WDT_CYCLES = 32'd1000000
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Fault,
  input  logic                  Fault_Clear,
  input  logic [31:0]           Target_0,
  input  logic [31:0]           Target_1,
  input  logic [31:0]           Target_2,
  pwm_drive_sequencer_if.master pwm,
  output logic [2:0]            State,
  output logic                  Busy
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRECHARGE = 3'd1, RAMP_UP = 3'd2, RUN = 3'd3, RAMP_DOWN = 3'd4, FAULT = 3'd5} state_t;
  state_t state, state_d;
  logic [31:0] duty [3], duty_d [3], tgt [3], up [3], dn [3];
  logic [31:0] cnt, cnt_d;
  logic en, en_d, irq_q, irq_clr, tick, trip, at_tgt, dn_zero, duty_zero;
  // Step toward the target by at most RAMP_STEP; the 33-bit sum keeps large targets from wrapping.
  function automatic logic [31:0] ramp_up(input logic [31:0] d, input logic [31:0] t);
    logic [32:0] s;
    s = {1'b0, d} + {1'b0, RAMP_STEP};
    return d < t ? (s > {1'b0, t} ? t : s[31:0]) : (d - t > RAMP_STEP ? d - RAMP_STEP : t);
  endfunction
  assign tick = pwm.Pwm_Irq & ~irq_q;
  assign tgt = '{Target_0, Target_1, Target_2};
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      up[k] = ramp_up(duty[k], tgt[k]);
      dn[k] = duty[k] > RAMP_STEP ? duty[k] - RAMP_STEP : '0;
    end
  end
  assign at_tgt = {up[0], up[1], up[2]} == {tgt[0], tgt[1], tgt[2]};
  assign dn_zero = ~|{dn[0], dn[1], dn[2]};
  assign duty_zero = ~|{duty[0], duty[1], duty[2]};
  always_comb begin
    state_d = state;
    duty_d = duty;
    en_d = en;
    cnt_d = cnt;
    case (state)
      IDLE: if (Start && !Stop) begin
        state_d = PRECHARGE;
        en_d = 1'b1;
        cnt_d = '0;
      end
      PRECHARGE: if (Stop) begin
        state_d = IDLE;
        en_d = 1'b0;
      end else if (tick) begin
        cnt_d = cnt + 32'd1;
        state_d = cnt_d == PRECHARGE_PERIODS ? RAMP_UP : PRECHARGE;
      end
      RAMP_UP, RUN: if (Stop) begin
        state_d = RAMP_DOWN;
        duty_d = tick ? dn : duty;
      end else if (tick) begin
        duty_d = state == RUN ? tgt : up;
        state_d = state == RUN || at_tgt ? RUN : RAMP_UP;
      end
      RAMP_DOWN: begin
        duty_d = tick ? dn : duty;
        if (tick ? dn_zero : duty_zero) begin
          state_d = IDLE;
          en_d = 1'b0;
        end
      end
      FAULT: state_d = !Fault && Fault_Clear ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
    if (Fault || trip) begin
      state_d = FAULT;
      en_d = 1'b0;
      duty_d = '{default: '0};
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      duty <= '{default: '0};
      en <= 1'b0;
      cnt <= '0;
      irq_q <= 1'b0;
      irq_clr <= 1'b0;
    end else begin
      state <= state_d;
      duty <= duty_d;
      en <= en_d;
      cnt <= cnt_d;
      irq_q <= pwm.Pwm_Irq;
      irq_clr <= tick;
    end
  end
`ifdef PWM_SEQ_WDOG_EN
  logic [31:0] wdt;
  assign trip = Busy && wdt == WDT_CYCLES - 32'd1;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wdt <= '0;
    else wdt <= !Busy || tick || state_d != state ? '0 : wdt + 32'd1;
  end
`else
  logic unused_wdt;
  assign trip = 1'b0;
  assign unused_wdt = ^WDT_CYCLES;
`endif
  assign State = state;
  assign Busy = state != IDLE && state != FAULT;
  assign pwm.Duty_0 = duty[0];
  assign pwm.Duty_1 = duty[1];
  assign pwm.Duty_2 = duty[2];
  assign pwm.Pwm_Enable = en;
  assign pwm.DeadTime_En = en;
  assign pwm.Irq_Enable = 1'b1;
  assign pwm.Irq_Clear = irq_clr;
endmodule

// File: tb/tb_pwm_drive_sequencer.sv
// tb_pwm_drive_sequencer: directed and randomized checks of the sequencer against a tick-level reference model
module tb_pwm_drive_sequencer;
  localparam int PP = 4;
  localparam logic [31:0] RS = 32'd64;
  localparam logic [31:0] WD = 32'd50;
  localparam longint MSTEP = 64;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Start = 1'b0, Stop = 1'b0, Fault = 1'b0, Fault_Clear = 1'b0;
  logic [31:0] Target_0 = '0, Target_1 = '0, Target_2 = '0;
  logic [2:0] State;
  logic Busy;
  int errors = 0, checks = 0;
  int m_state = 0, m_cnt = 0;
  bit m_en = 1'b0;
  longint m_d [3] = '{0, 0, 0};
  longint tg [3] = '{0, 0, 0};
  pwm_drive_sequencer_if pif();
  pwm_drive_sequencer #(.PRECHARGE_PERIODS(PP), .RAMP_STEP(RS), .WDT_CYCLES(WD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop), .Fault(Fault), .Fault_Clear(Fault_Clear),
    .Target_0(Target_0), .Target_1(Target_1), .Target_2(Target_2), .pwm(pif), .State(State), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  function automatic longint lmin(input longint a, input longint b);
    return a < b ? a : b;
  endfunction
  function automatic longint lmax(input longint a, input longint b);
    return a > b ? a : b;
  endfunction
  function automatic bit m_all_zero();
    return m_d[0] == 0 && m_d[1] == 0 && m_d[2] == 0;
  endfunction
  function automatic void m_down();
    for (int k = 0; k < 3; k++) m_d[k] = lmax(m_d[k] - MSTEP, 0);
  endfunction
  function automatic void m_tick();
    bit done;
    case (m_state)
      1: begin
        m_cnt++;
        if (m_cnt == PP) m_state = 2;
      end
      2, 3: if (Stop) begin
        m_state = 4;
        m_down();
      end else begin
        done = 1'b1;
        for (int k = 0; k < 3; k++) begin
          m_d[k] = (m_state == 3) ? tg[k] : (m_d[k] < tg[k]) ? lmin(m_d[k] + MSTEP, tg[k]) : lmax(m_d[k] - MSTEP, tg[k]);
          if (m_d[k] != tg[k]) done = 1'b0;
        end
        if (done) m_state = 3;
      end
      4: begin
        m_down();
        if (m_all_zero()) begin
          m_state = 0;
          m_en = 1'b0;
        end
      end
      default: ;
    endcase
  endfunction
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge Clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(State), 32'(m_state));
    chk({tag, ".duty0"}, pif.Duty_0, 32'(m_d[0]));
    chk({tag, ".duty1"}, pif.Duty_1, 32'(m_d[1]));
    chk({tag, ".duty2"}, pif.Duty_2, 32'(m_d[2]));
    chk({tag, ".pwm_en"}, 32'(pif.Pwm_Enable), 32'(m_en));
    chk({tag, ".deadtime_en"}, 32'(pif.DeadTime_En), 32'(m_en));
    chk({tag, ".busy"}, 32'(Busy), 32'(m_state >= 1 && m_state <= 4));
    chk({tag, ".irq_en"}, 32'(pif.Irq_Enable), 32'd1);
  endtask
  task automatic set_tg(input longint a, input longint b, input longint c);
    tg = '{a, b, c};
    Target_0 = 32'(a);
    Target_1 = 32'(b);
    Target_2 = 32'(c);
  endtask
  task automatic tick(input int per, input int hi);
    pif.Pwm_Irq = 1'b1;
    step(1);
    m_tick();
    check_all("tick");
    chk("irq_clear.pulse", 32'(pif.Irq_Clear), 32'd1);
    step(1);
    chk("irq_clear.single", 32'(pif.Irq_Clear), 32'd0);
    if (hi > 2) step(hi - 2);
    pif.Pwm_Irq = 1'b0;
    step(per - hi);
  endtask
  task automatic do_start();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    if (m_state == 0 && !Stop) begin
      m_state = 1;
      m_en = 1'b1;
      m_cnt = 0;
    end
    check_all("start");
  endtask
  task automatic do_stop();
    Stop = 1'b1;
    step(1);
    if (m_state == 1) begin
      m_state = 0;
      m_en = 1'b0;
    end else if (m_state == 2 || m_state == 3) m_state = 4;
    check_all("stop");
  endtask
  initial begin
    int exp_up [4];
    int exp_dn [4];
    exp_up = '{64, 128, 192, 200};
    exp_dn = '{136, 72, 8, 0};
    pif.Pwm_Irq = 1'b0;
    step(2);
    check_all("reset");
    Reset_n = 1'b1;
    step(1);
    check_all("idle");
    do_start();
    set_tg(200, 64, 0);
    repeat (PP) tick(30, 3);
    chk("pre.done", 32'(State), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick(30, 3);
      chk("ramp.duty0", pif.Duty_0, 32'(exp_up[i]));
      chk("ramp.duty1", pif.Duty_1, 32'd64);
      chk("ramp.duty2", pif.Duty_2, 32'd0);
    end
    chk("ramp.run", 32'(State), 32'd3);
    set_tg(300, 64, 0);
    step(5);
    check_all("run.hold");
    chk("run.hold200", pif.Duty_0, 32'd200);
    tick(30, 3);
    chk("run.track300", pif.Duty_0, 32'd300);
    set_tg(200, 64, 0);
    tick(30, 25);
    chk("run.back200", pif.Duty_0, 32'd200);
    check_all("run.stuck_irq");
    do_stop();
    for (int i = 0; i < 4; i++) begin
      tick(30, 3);
      chk("down.duty0", pif.Duty_0, 32'(exp_dn[i]));
    end
    chk("down.idle", 32'(State), 32'd0);
    chk("down.pwm_en", 32'(pif.Pwm_Enable), 32'd0);
    Stop = 1'b0;
    step(1);
    check_all("idle2");
    for (int r = 0; r < 4; r++) begin
      do_start();
      repeat (PP) tick($urandom_range(20, 30), $urandom_range(2, 6));
      set_tg($urandom_range(100, 700), $urandom_range(100, 700), $urandom_range(100, 700));
      for (int i = 0; i < 40 && m_state == 2; i++) tick($urandom_range(20, 30), $urandom_range(2, 6));
      chk("rnd.run", 32'(State), 32'd3);
      repeat (2) begin
        set_tg($urandom_range(100, 700), $urandom_range(100, 700), $urandom_range(100, 700));
        step($urandom_range(1, 10));
        check_all("rnd.hold");
        tick($urandom_range(20, 30), $urandom_range(2, 6));
      end
      if (r % 2 == 1) begin
        Stop = 1'b1;
        tick($urandom_range(20, 30), $urandom_range(2, 6));
      end else do_stop();
      for (int i = 0; i < 40 && m_state == 4; i++) tick($urandom_range(20, 30), $urandom_range(2, 6));
      chk("rnd.idle", 32'(State), 32'd0);
      Stop = 1'b0;
      step(1);
    end
    do_start();
    repeat (PP) tick(30, 3);
    set_tg(500, 500, 500);
    tick(30, 3);
    Fault = 1'b1;
    step(1);
    m_state = 5;
    m_en = 1'b0;
    m_d = '{0, 0, 0};
    check_all("fault");
    Fault_Clear = 1'b1;
    step(1);
    check_all("fault.clear_ignored");
    Fault_Clear = 1'b0;
    Fault = 1'b0;
    step(1);
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    check_all("fault.start_ignored");
    Fault_Clear = 1'b1;
    step(1);
    Fault_Clear = 1'b0;
    m_state = 0;
    check_all("fault.cleared");
    step(1);
    check_all("fault.stay_idle");
    do_start();
    repeat (PP) tick(30, 3);
    for (int i = 0; i < 20 && m_state == 2; i++) tick(30, 3);
    chk("rst.run500", pif.Duty_0, 32'd500);
    #3;
    Reset_n = 1'b0;
    #1;
    m_state = 0;
    m_en = 1'b0;
    m_d = '{0, 0, 0};
    check_all("async_rst");
    chk("async_rst.irq_clear", 32'(pif.Irq_Clear), 32'd0);
    step(1);
    Reset_n = 1'b1;
    step(1);
    check_all("post_rst");
`ifdef PWM_SEQ_WDOG_EN
    do_start();
    repeat (PP) tick(25, 3);
    set_tg(64, 64, 64);
    pif.Pwm_Irq = 1'b1;
    step(1);
    m_tick();
    check_all("wdog.run");
    pif.Pwm_Irq = 1'b0;
    step(49);
    chk("wdog.hold", 32'(State), 32'd3);
    step(1);
    m_state = 5;
    m_en = 1'b0;
    m_d = '{0, 0, 0};
    check_all("wdog.trip");
    Fault_Clear = 1'b1;
    step(1);
    Fault_Clear = 1'b0;
    m_state = 0;
    check_all("wdog.cleared");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
